mask_pack: RTL and testbench
============================

Name: mask_pack

Overview:
- Downstream of the per-element compare/mask-logic datapath in the normal ALU.
- Collects the 1-bit result produced for each element (vmseq/vmslt/vmand/...) into DATA_WIDTH-wide mask words.
- Writes each packed word to the vector register file write port with a valid/ready handshake.
- Sequenced by a start/vl pair from the vector control unit.

Parameters:
- DATA_WIDTH, 32, mask word width and bits per VRF write.
- VLEN_MAX, 256, maximum element count per instruction; must be a multiple of DATA_WIDTH.
- CNT_W, $clog2(VLEN_MAX)+1, element counter and vl width (derived).
- IDX_W, $clog2(VLEN_MAX/DATA_WIDTH), word index width (derived).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, synchronous, active-low.
- start_i  in  1  begin a new instruction; sampled only in IDLE.
- vl_i  in  CNT_W  element count, sampled with start_i; 0..VLEN_MAX.
- valid_i  in  1  result bit valid.
- bit_i  in  1  result bit of current element.
- ready_o  out  1  block accepts bit_i this cycle.
- wr_en_o  out  1  write request valid.
- wr_idx_o  out  IDX_W  mask word index in destination register.
- wr_data_o  out  DATA_WIDTH  packed mask word.
- wr_ready_i  in  1  VRF accepts write.
- busy_o  out  1  instruction in progress.
- done_o  out  1  one-cycle pulse when last write is accepted.

Behaviour:
- Reset (rst_ni=0 at rising edge): state IDLE.
  - ready_o, wr_en_o, busy_o, done_o = 0.
  - wr_idx_o = 0, wr_data_o = 0; element counter and word buffer cleared.
- Reset mid-instruction aborts it. No write or done_o follows.
- Sequential FSM, states IDLE, COLLECT, WRITE, DONE:
  - IDLE:
    - start_i with vl_i>0: latch vl, clear counter, go COLLECT.
    - start_i with vl_i=0: go DONE directly; no write is issued.
    - busy_o=0.
  - COLLECT:
    - ready_o=1, busy_o=1.
    - On valid_i&&ready_o: set buffer bit (elem_cnt mod DATA_WIDTH) = bit_i, increment elem_cnt.
    - If that bit fills the word (bit position DATA_WIDTH-1) or is element vl-1: go WRITE next cycle.
  - WRITE:
    - ready_o=0, wr_en_o=1.
    - wr_data_o and wr_idx_o stay stable until wr_ready_i.
    - On wr_ready_i: clear buffer and increment wr_idx.
    - Then go DONE if elem_cnt==vl, else COLLECT.
  - DONE:
    - done_o=1 for exactly one cycle; busy_o=0.
    - Return to IDLE with wr_idx reset to 0.
- Latency: the accepting cycle of the word-completing bit is cycle N; wr_en_o rises at cycle N+1. Final write accepted at cycle M gives done_o at cycle M+1.
- Bit order: element i maps to bit (i mod DATA_WIDTH) of word (i / DATA_WIDTH).
- Tail policy (mask results are tail-agnostic): bits at positions >= vl in the last word are written as 1.
- start_i outside IDLE is ignored.
- valid_i while ready_o=0 is not consumed; the producer holds the bit.
- Throughput: one bit per cycle. Each word costs at least one extra WRITE cycle, during which input stalls.
- vl=VLEN_MAX: exactly VLEN_MAX/DATA_WIDTH writes. The counter must not wrap; CNT_W covers VLEN_MAX.

Optional Feature:
- Macro: MASK_PACK_POPCNT_EN.
- Defined:
  - Adds output popcnt_o, width CNT_W.
  - Popcount of accepted bits for the current instruction; tail fill is excluded.
  - Cleared on start in IDLE.
  - Valid and stable from the done_o cycle until the next start. Serves vcpop.m.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Shared vect_pkg:
  - state enum mask_pack_state_t {IDLE, COLLECT, WRITE, DONE}.
  - constant MASK_TAIL_FILL = 1'b1.
- No sub-module needed. Bit insertion and tail fill are an inline combinational mask: bits >= (vl mod DATA_WIDTH) are set when the word is last and partial.

Test Plan:
- Reset with wr_ready_i=1, valid_i=1 held -> all outputs 0; no wr_en_o until start.
- vl=32, bits = element index parity (1,0,1,0...), wr_ready_i=1 -> one write:
  - idx 0, data 0x55555555, asserted the cycle after element 31.
  - done_o follows the next cycle.
- vl=40, all bits 0 -> two writes:
  - idx0 = 0x00000000.
  - idx1 = 0xFFFFFF00 (tail ones).
  - ready_o low during each WRITE.
- vl=0 -> done_o one cycle after start; no wr_en_o.
- vl=64, wr_ready_i low for 5 cycles on first write:
  - wr_data_o/wr_idx_o stable.
  - ready_o=0 throughout; valid_i bits not lost.
- rst_ni low after 10 of 32 elements, then start vl=8 with all 1s -> single write 0xFFFFFFFF at idx 0. With MASK_PACK_POPCNT_EN, popcnt_o=8.

Source files
------------

// File: rtl/vect_pkg.sv
// Shared vector-unit types: mask packer state encoding and tail fill value.
package vect_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } mask_pack_state_t;

  // Mask results are tail-agnostic; unused tail bits are written as ones.
  localparam logic MASK_TAIL_FILL = 1'b1;

endpackage

// File: rtl/mask_pack.sv
// Packs per-element compare/mask result bits into mask words for the VRF write port.
// Optional popcount output (vcpop.m) enabled by defining MASK_PACK_POPCNT_EN.
module mask_pack
  import vect_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int VLEN_MAX   = 256,
  localparam int CNT_W     = $clog2(VLEN_MAX) + 1,
  localparam int IDX_W     = $clog2(VLEN_MAX / DATA_WIDTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [CNT_W-1:0]      vl_i,
  input  logic                  valid_i,
  input  logic                  bit_i,
  output logic                  ready_o,
  output logic                  wr_en_o,
  output logic [IDX_W-1:0]      wr_idx_o,
  output logic [DATA_WIDTH-1:0] wr_data_o,
  input  logic                  wr_ready_i,
  output logic                  busy_o,
  output logic                  done_o
`ifdef MASK_PACK_POPCNT_EN
  ,
  output logic [CNT_W-1:0]      popcnt_o
`endif
);

  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [IDX_W-1:0] IDX_ONE = 1;

  mask_pack_state_t      state_reg;
  logic [CNT_W-1:0]      vl_reg;
  logic [CNT_W-1:0]      elem_cnt_reg;
  logic [DATA_WIDTH-1:0] buf_reg;
  logic [DATA_WIDTH-1:0] buf_next;
  logic [DATA_WIDTH-1:0] tail_mask;
  logic [IDX_W-1:0]      wr_idx_reg;
  logic                  ready_reg;
  logic                  wr_en_reg;
  logic                  busy_reg;
  logic                  done_reg;

  logic                  accept;
  logic                  last_elem;
  logic                  word_full;
  logic [BW-1:0]         bit_pos;
  logic [BW-1:0]         vl_mod;

  assign accept    = (state_reg == COLLECT) && valid_i;
  assign bit_pos   = elem_cnt_reg[BW-1:0];
  assign vl_mod    = vl_reg[BW-1:0];
  assign last_elem = (elem_cnt_reg == vl_reg - CNT_ONE);
  assign word_full = &bit_pos;

  // Tail positions only exist when the final word is partial (vl not word aligned).
  assign tail_mask = (last_elem && (vl_mod != '0)) ?
                     ({DATA_WIDTH{1'b1}} << vl_mod) : '0;

  for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_bit
    assign buf_next[gi] = tail_mask[gi]                ? MASK_TAIL_FILL :
                          (BW'(gi) == bit_pos)         ? bit_i          :
                                                         buf_reg[gi];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_reg    <= IDLE;
      vl_reg       <= '0;
      elem_cnt_reg <= '0;
      buf_reg      <= '0;
      wr_idx_reg   <= '0;
      ready_reg    <= 1'b0;
      wr_en_reg    <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start_i) begin
            vl_reg       <= vl_i;
            elem_cnt_reg <= '0;
            buf_reg      <= '0;
            wr_idx_reg   <= '0;
            if (vl_i != '0) begin
              state_reg <= COLLECT;
              ready_reg <= 1'b1;
              busy_reg  <= 1'b1;
            end else begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
            end
          end
        end
        COLLECT: begin
          if (accept) begin
            buf_reg      <= buf_next;
            elem_cnt_reg <= elem_cnt_reg + CNT_ONE;
            if (word_full || last_elem) begin
              state_reg <= WRITE;
              ready_reg <= 1'b0;
              wr_en_reg <= 1'b1;
            end
          end
        end
        WRITE: begin
          // Data and index are held until the VRF takes them.
          if (wr_ready_i) begin
            wr_en_reg  <= 1'b0;
            buf_reg    <= '0;
            wr_idx_reg <= wr_idx_reg + IDX_ONE;
            if (elem_cnt_reg == vl_reg) begin
              state_reg <= DONE;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= COLLECT;
              ready_reg <= 1'b1;
            end
          end
        end
        DONE: begin
          state_reg  <= IDLE;
          done_reg   <= 1'b0;
          wr_idx_reg <= '0;
        end
        default: begin
          state_reg <= IDLE;
          ready_reg <= 1'b0;
          wr_en_reg <= 1'b0;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

`ifdef MASK_PACK_POPCNT_EN
  logic [CNT_W-1:0] popcnt_reg;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      popcnt_reg <= '0;
    end else if ((state_reg == IDLE) && start_i) begin
      popcnt_reg <= '0;
    end else if (accept && bit_i) begin
      popcnt_reg <= popcnt_reg + CNT_ONE;
    end
  end

  assign popcnt_o = popcnt_reg;
`endif

  assign ready_o   = ready_reg;
  assign wr_en_o   = wr_en_reg;
  assign wr_idx_o  = wr_idx_reg;
  assign wr_data_o = buf_reg;
  assign busy_o    = busy_reg;
  assign done_o    = done_reg;

endmodule

// File: tb/tb_mask_pack.sv
// Directed, table-driven bench for mask_pack with hand-computed mask words.
// Checks popcnt_o as well when MASK_PACK_POPCNT_EN is defined.
module tb_mask_pack;

  localparam int DW    = 32;
  localparam int CNT_W = 9;
  localparam int IDX_W = 3;

  logic             clk = 1'b0;
  logic             rst_ni;
  logic             start_i;
  logic [CNT_W-1:0] vl_i;
  logic             valid_i;
  logic             bit_i;
  logic             ready_o;
  logic             wr_en_o;
  logic [IDX_W-1:0] wr_idx_o;
  logic [DW-1:0]    wr_data_o;
  logic             wr_ready_i;
  logic             busy_o;
  logic             done_o;
`ifdef MASK_PACK_POPCNT_EN
  logic [CNT_W-1:0] popcnt_o;
`endif

  mask_pack dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .start_i    (start_i),
    .vl_i       (vl_i),
    .valid_i    (valid_i),
    .bit_i      (bit_i),
    .ready_o    (ready_o),
    .wr_en_o    (wr_en_o),
    .wr_idx_o   (wr_idx_o),
    .wr_data_o  (wr_data_o),
    .wr_ready_i (wr_ready_i),
    .busy_o     (busy_o),
    .done_o     (done_o)
`ifdef MASK_PACK_POPCNT_EN
    ,
    .popcnt_o   (popcnt_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int               vl;
    int               pat;
    int               stall;
    int               nw;
    logic [7:0][31:0] d;
  } vec_t;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // 0: 1,0,1,0...  1: all zero  2: all one  3: element index divisible by 3
  function automatic logic pat_bit(input int pat, input int i);
    case (pat)
      0:       return (i % 2) == 0;
      1:       return 1'b0;
      2:       return 1'b1;
      default: return (i % 3) == 0;
    endcase
  endfunction

  function automatic vec_t mk(input int vl, input int pat, input int stall, input int nw);
    vec_t v;
    v.vl = vl; v.pat = pat; v.stall = stall; v.nw = nw; v.d = '0;
    return v;
  endfunction

  task automatic run(input vec_t v);
    int   idx = 0, nw = 0, cyc = 0, stall = v.stall, ones = 0;
    bit   wr_due = 0, done_due = 0, seen_done = 0, prev_wr_en = 0, held = 0;
    bit   lat_bad = 0, excl_bad = 0, stable_bad = 0, done_bad = 0;
    logic [31:0]      hd = '0;
    logic [IDX_W-1:0] hi = '0;
    @(negedge clk);
    start_i = 1'b1; vl_i = CNT_W'(v.vl); valid_i = 1'b0; wr_ready_i = 1'b0;
    @(negedge clk);
    start_i = 1'b0;
    while (!seen_done && cyc < 3000) begin
      if (done_o) begin
        seen_done = 1;
        if (!((v.vl == 0) ? (cyc == 0) : done_due)) done_bad = 1;
        check($sformatf("busy_at_done vl=%0d", v.vl), 64'(busy_o), 64'd0);
`ifdef MASK_PACK_POPCNT_EN
        check($sformatf("popcnt vl=%0d", v.vl), 64'(popcnt_o), 64'(ones));
`endif
      end else if (done_due) begin
        done_bad = 1;
      end
      if (cyc == 0 && v.vl > 0)
        check($sformatf("busy_ready_start vl=%0d", v.vl), {62'd0, busy_o, ready_o}, 64'd3);
      if (wr_due && !wr_en_o) lat_bad = 1;
      if (wr_en_o && !prev_wr_en && !wr_due) lat_bad = 1;
      if (ready_o && wr_en_o) excl_bad = 1;
      if (held && (wr_data_o !== hd || wr_idx_o !== hi)) stable_bad = 1;
      if (seen_done) break;

      start_i    = (cyc == 3);
      vl_i       = '0;
      valid_i    = (idx < v.vl);
      bit_i      = pat_bit(v.pat, idx);
      wr_ready_i = !(wr_en_o && stall > 0);
      if (wr_en_o && stall > 0) stall--;
      done_due = wr_en_o && wr_ready_i && (nw == v.nw - 1);
      wr_due   = 0;
      held     = 0;
      if (valid_i && ready_o) begin
        ones   += int'(bit_i);
        wr_due = ((idx % DW) == DW - 1) || (idx == v.vl - 1);
        idx++;
      end
      if (wr_en_o) begin
        if (wr_ready_i) begin
          $display("vl=%0d write idx=%0d data=%08h", v.vl, wr_idx_o, wr_data_o);
          check($sformatf("wr_idx vl=%0d #%0d", v.vl, nw), 64'(wr_idx_o), 64'(nw % 8));
          check($sformatf("wr_data vl=%0d #%0d", v.vl, nw), 64'(wr_data_o),
                64'((nw < 8) ? v.d[nw] : 32'h0));
          nw++;
        end else begin
          held = 1; hd = wr_data_o; hi = wr_idx_o;
        end
      end
      prev_wr_en = wr_en_o;
      cyc++;
      @(negedge clk);
    end
    start_i = 1'b0; valid_i = 1'b0; wr_ready_i = 1'b0;
    check($sformatf("done_seen vl=%0d", v.vl), 64'(seen_done), 64'd1);
    check($sformatf("write_count vl=%0d", v.vl), 64'(nw), 64'(v.nw));
    check($sformatf("wr_latency vl=%0d", v.vl), 64'(lat_bad), 64'd0);
    check($sformatf("done_timing vl=%0d", v.vl), 64'(done_bad), 64'd0);
    check($sformatf("ready_in_write vl=%0d", v.vl), 64'(excl_bad), 64'd0);
    check($sformatf("stall_stable vl=%0d", v.vl), 64'(stable_bad), 64'd0);
    @(negedge clk);
    check($sformatf("done_pulse_end vl=%0d", v.vl), {62'd0, done_o, busy_o}, 64'd0);
    $display("instr vl=%0d pat=%0d stall=%0d writes=%0d", v.vl, v.pat, v.stall, nw);
  endtask

  vec_t vecs[8];

  initial begin
    bit bad;

    vecs[0] = mk(32, 0, 0, 1);  vecs[0].d[0] = 32'h55555555;
    vecs[1] = mk(40, 1, 0, 2);  vecs[1].d[0] = 32'h00000000; vecs[1].d[1] = 32'hFFFFFF00;
    vecs[2] = mk(0, 1, 0, 0);
    vecs[3] = mk(64, 3, 5, 2);  vecs[3].d[0] = 32'h49249249; vecs[3].d[1] = 32'h92492492;
    vecs[4] = mk(256, 2, 0, 8);
    for (int i = 0; i < 8; i++) vecs[4].d[i] = 32'hFFFFFFFF;
    vecs[5] = mk(1, 1, 0, 1);   vecs[5].d[0] = 32'hFFFFFFFE;
    vecs[6] = mk(31, 0, 2, 1);  vecs[6].d[0] = 32'hD5555555;
    vecs[7] = mk(33, 2, 0, 2);  vecs[7].d[0] = 32'hFFFFFFFF; vecs[7].d[1] = 32'hFFFFFFFF;

    // Reset with write-ready and valid asserted
    rst_ni = 1'b0; start_i = 1'b0; vl_i = '0; valid_i = 1'b1; bit_i = 1'b1; wr_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_ctrl", {60'd0, ready_o, wr_en_o, busy_o, done_o}, 64'd0);
    check("reset_idx", 64'(wr_idx_o), 64'd0);
    check("reset_data", 64'(wr_data_o), 64'd0);
    rst_ni = 1'b1;
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (wr_en_o || busy_o || ready_o) bad = 1;
    end
    check("idle_no_activity", 64'(bad), 64'd0);
    valid_i = 1'b0; wr_ready_i = 1'b0;

    foreach (vecs[k]) run(vecs[k]);

    // Reset partway through a 32-element instruction
    @(negedge clk);
    start_i = 1'b1; vl_i = CNT_W'(32);
    @(negedge clk);
    start_i = 1'b0; valid_i = 1'b1; bit_i = 1'b1; wr_ready_i = 1'b1;
    repeat (10) @(negedge clk);
    rst_ni = 1'b0;
    bad = 0;
    repeat (2) begin
      @(negedge clk);
      if (wr_en_o || done_o) bad = 1;
    end
    check("midreset_outputs", {60'd0, ready_o, wr_en_o, busy_o, done_o}, 64'd0);
    check("midreset_data", 64'(wr_data_o), 64'd0);
    rst_ni = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (wr_en_o || done_o || busy_o) bad = 1;
    end
    check("midreset_aborted", 64'(bad), 64'd0);
    valid_i = 1'b0; wr_ready_i = 1'b0;
    begin
      vec_t v8;
      v8 = mk(8, 2, 0, 1);
      v8.d[0] = 32'hFFFFFFFF;
      run(v8);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
